cache_cmd_queue: RTL and testbench
==================================

CACHE_CMD_QUEUE -- requirements
Module: cache_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter KEY_WIDTH, default 16, key width.
REQ-003 SHALL have parameter VALUE_WIDTH, default 64, value width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before error.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid_i  input  1, cmd_ready_o  output  1: command handshake.
REQ-008 SHALL have ports cmd_op_i  input  2, cmd_key_i  input  KEY_WIDTH, cmd_val_i  input  VALUE_WIDTH: command fields.
REQ-009 SHALL have ports core_op_o  output  2, core_key_o  output  KEY_WIDTH, core_val_o  output  VALUE_WIDTH: registered command to cache core.
REQ-010 SHALL have ports core_start_o  output  1 (issue pulse), core_busy_i  input  1, core_done_i  input  1, core_hit_i  input  1, core_rdata_i  input  VALUE_WIDTH.
REQ-011 SHALL have ports rsp_valid_o  output  1, rsp_ready_i  input  1, rsp_op_o  output  2, rsp_hit_o  output  1, rsp_err_o  output  1, rsp_data_o  output  VALUE_WIDTH.
REQ-012 SHALL have port level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Op encoding SHALL be 00 READ, 01 WRITE, 10 DELETE, 11 reserved.
REQ-014 Command SHALL be pushed on rising edge where cmd_valid_i && cmd_ready_o; cmd_ready_o SHALL equal (level_o != DEPTH), with no same-cycle pop forwarding.
REQ-015 Read/write pointers SHALL wrap modulo DEPTH; push and pop in same cycle SHALL leave level_o unchanged.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if FIFO non-empty and core_busy_i==0, pop head into core_*_o registers; go ISSUE if op!=11, else go RESP with rsp_err_o=1, rsp_hit_o=0, rsp_data_o=0.
REQ-018 ISSUE: core_start_o SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-019 WAIT: core_done_i SHALL be sampled only here; on core_done_i capture core_hit_i, core_rdata_i (zero for WRITE/DELETE), rsp_err_o=0, go RESP.
REQ-020 WAIT: cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT without core_done_i, go RESP with rsp_err_o=1, rsp_hit_o=0.
REQ-021 RESP: rsp_valid_o=1 and rsp_* SHALL stay stable until rsp_ready_i; on handshake go IDLE.
REQ-022 Min latency accept->core_start_o SHALL be 2 cycles (push edge, pop edge); core_done_i->rsp_valid_o 1 cycle.
REQ-023 Only one command SHALL be outstanding at the core; FIFO SHALL keep accepting while FSM is busy.
REQ-024 core_done_i outside WAIT SHALL be ignored.

Reset
REQ-025 On rst_n low, asynchronously: FSM=IDLE, pointers and level_o=0, cmd_ready_o=1, core_start_o=0, core_op_o/key/val=0, rsp_valid_o=0, rsp_*=0, timeout counter=0.
REQ-026 Reset mid-operation SHALL discard all queued and in-flight commands with no response.

Configuration
REQ-027 Macro CMD_QUEUE_STATS_EN defined: add outputs stat_cmds_o 16 (responses delivered) and stat_hits_o 16 (responses with rsp_hit_o=1), both saturating at 16'hFFFF, reset to 0.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Empty queue, core idle, push READ key 0x0042 -> core_start_o high 2 cycles later with core_key_o=0x0042; core_done_i, hit=1, rdata=0xDEAD -> next cycle rsp_valid_o=1, rsp_hit_o=1, rsp_data_o=0xDEAD.
REQ-030 core_busy_i=1, push 4 commands (DEPTH=4) -> level_o=4, cmd_ready_o=0; 5th held off; release busy -> commands issued in order, level_o decrements.
REQ-031 Push op 11 -> no core_start_o; rsp_err_o=1, rsp_hit_o=0.
REQ-032 Issue READ, never assert core_done_i -> rsp_valid_o=1 with rsp_err_o=1 after TIMEOUT cycles in WAIT.
REQ-033 rsp_ready_i held low 10 cycles -> rsp_* stable, no further core_start_o; assert rsp_ready_i -> next command issued.
REQ-034 Assert rst_n low during WAIT with 3 queued -> all outputs at reset values, level_o=0, no response after release.

Source files
------------

// File: rtl/cache_cmd_queue_if.sv
// Command / cache-core / response bundle for cache_cmd_queue.
// slave is the queue side, master is the requester/core side.
interface cache_cmd_queue_if #(
  parameter int DEPTH       = 4,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 64
);
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [1:0]             cmd_op_i;
  logic [KEY_WIDTH-1:0]   cmd_key_i;
  logic [VALUE_WIDTH-1:0] cmd_val_i;

  logic [1:0]             core_op_o;
  logic [KEY_WIDTH-1:0]   core_key_o;
  logic [VALUE_WIDTH-1:0] core_val_o;
  logic                   core_start_o;
  logic                   core_busy_i;
  logic                   core_done_i;
  logic                   core_hit_i;
  logic [VALUE_WIDTH-1:0] core_rdata_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [1:0]             rsp_op_o;
  logic                   rsp_hit_o;
  logic                   rsp_err_o;
  logic [VALUE_WIDTH-1:0] rsp_data_o;

  logic [$clog2(DEPTH):0] level_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_key_i, cmd_val_i,
    input  core_busy_i, core_done_i, core_hit_i, core_rdata_i,
    input  rsp_ready_i,
    output cmd_ready_o,
    output core_op_o, core_key_o, core_val_o, core_start_o,
    output rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_err_o, rsp_data_o,
    output level_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_key_i, cmd_val_i,
    output core_busy_i, core_done_i, core_hit_i, core_rdata_i,
    output rsp_ready_i,
    input  cmd_ready_o,
    input  core_op_o, core_key_o, core_val_o, core_start_o,
    input  rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_err_o, rsp_data_o,
    input  level_o
  );
endinterface

// File: rtl/cache_cmd_queue.sv
// Command FIFO feeding a single-outstanding cache core with a held response.
// Optional response/hit counters are built when CMD_QUEUE_STATS_EN is defined.
module cache_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_cmd_queue_if.slave  bus
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]       stat_cmds_o,
  output logic [15:0]       stat_hits_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [1:0]             op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] val;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [TMR_W-1:0] wait_cnt;
  state_t           state;
  logic             cmd_ready;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot early.
  assign cmd_ready       = (level != LVL_W'(DEPTH));
  assign push            = bus.cmd_valid_i && cmd_ready;
  assign pop             = (state == IDLE) && (level != '0) && !bus.core_busy_i;
  assign head            = mem[rd_ptr];
  assign bus.cmd_ready_o = cmd_ready;
  assign bus.level_o     = level;

  // Storage holds payload only; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: bus.cmd_op_i, key: bus.cmd_key_i, val: bus.cmd_val_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Control FSM; every core_* and rsp_* output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      bus.core_start_o <= 1'b0;
      bus.core_op_o    <= '0;
      bus.core_key_o   <= '0;
      bus.core_val_o   <= '0;
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_op_o     <= '0;
      bus.rsp_hit_o    <= 1'b0;
      bus.rsp_err_o    <= 1'b0;
      bus.rsp_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.core_op_o  <= head.op;
            bus.core_key_o <= head.key;
            bus.core_val_o <= head.val;
            if (head.op == OP_RSVD) begin
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_op_o    <= head.op;
              bus.rsp_hit_o   <= 1'b0;
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_data_o  <= '0;
              state           <= RESP;
            end else begin
              bus.core_start_o <= 1'b1;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.core_start_o <= 1'b0;
          wait_cnt         <= '0;
          state            <= WAIT;
        end
        WAIT: begin
          if (bus.core_done_i) begin
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_op_o    <= bus.core_op_o;
            bus.rsp_hit_o   <= bus.core_hit_i;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_data_o  <= (bus.core_op_o == OP_READ) ? bus.core_rdata_i : '0;
            state           <= RESP;
          end else if (wait_cnt == TMR_W'(TIMEOUT - 1)) begin
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_op_o    <= bus.core_op_o;
            bus.rsp_hit_o   <= 1'b0;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_data_o  <= '0;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMD_QUEUE_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmds_o <= '0;
      stat_hits_o <= '0;
    end else if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      stat_cmds_o <= sat_inc16(stat_cmds_o);
      if (bus.rsp_hit_o) stat_hits_o <= sat_inc16(stat_hits_o);
    end
  end
`endif

endmodule

// File: tb/tb_cache_cmd_queue.sv
// Randomized bench for cache_cmd_queue against a transaction-level queue model.
module tb_cache_cmd_queue;
  localparam int DEPTH = 4;
  localparam int KW    = 16;
  localparam int VW    = 64;
  localparam int TO    = 12;

  localparam int PH_FREE  = 0;
  localparam int PH_START = 1;
  localparam int PH_CORE  = 2;
  localparam int PH_RSP   = 3;

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  cmd_t          mq[$];
  cmd_t          m_cur;
  int            m_level;
  int            m_ph;
  int            m_wait;
  logic [1:0]    m_rop;
  logic          m_rhit;
  logic          m_rerr;
  logic [VW-1:0] m_rdata;
`ifdef CMD_QUEUE_STATS_EN
  logic [15:0]   stat_cmds;
  logic [15:0]   stat_hits;
  int            m_cmds;
  int            m_hits;
`endif

  always #5 clk = ~clk;

  cache_cmd_queue_if #(.DEPTH(DEPTH), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

  cache_cmd_queue #(.DEPTH(DEPTH), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CMD_QUEUE_STATS_EN
    ,
    .stat_cmds_o (stat_cmds),
    .stat_hits_o (stat_hits)
`endif
  );

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_op_i     = 2'd0;
    bus.cmd_key_i    = '0;
    bus.cmd_val_i    = '0;
    bus.core_busy_i  = 1'b0;
    bus.core_done_i  = 1'b0;
    bus.core_hit_i   = 1'b0;
    bus.core_rdata_i = '0;
    bus.rsp_ready_i  = 1'b1;
  endtask

  task automatic rand_inputs(input int p_valid, input int p_busy, input int p_done, input int p_ready);
    bus.cmd_valid_i  = ($urandom_range(99) < p_valid);
    bus.cmd_op_i     = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
    bus.cmd_key_i    = KW'($urandom);
    bus.cmd_val_i    = {$urandom, $urandom};
    bus.core_busy_i  = ($urandom_range(99) < p_busy);
    bus.core_done_i  = ($urandom_range(99) < p_done);
    bus.core_hit_i   = 1'($urandom_range(1));
    bus.core_rdata_i = {$urandom, $urandom};
    bus.rsp_ready_i  = ($urandom_range(99) < p_ready);
  endtask

  task automatic model_clear();
    mq.delete();
    m_level = 0;
    m_ph    = PH_FREE;
    m_wait  = 0;
`ifdef CMD_QUEUE_STATS_EN
    m_cmds  = 0;
    m_hits  = 0;
`endif
  endtask

  // What one rising edge does, expressed on whole commands and responses.
  task automatic model_edge();
    bit   accepted;
    bit   taken;
    cmd_t c;
    accepted = bus.cmd_valid_i && (m_level != DEPTH);
    taken    = 1'b0;
    case (m_ph)
      PH_FREE: begin
        if (mq.size() != 0 && !bus.core_busy_i) begin
          m_cur = mq.pop_front();
          taken = 1'b1;
          if (m_cur.op == 2'd3) begin
            m_rop = 2'd3; m_rhit = 1'b0; m_rerr = 1'b1; m_rdata = '0;
            m_ph  = PH_RSP;
          end else begin
            m_ph = PH_START;
          end
        end
      end
      PH_START: begin
        m_ph   = PH_CORE;
        m_wait = 0;
      end
      PH_CORE: begin
        if (bus.core_done_i) begin
          m_rop   = m_cur.op;
          m_rhit  = bus.core_hit_i;
          m_rerr  = 1'b0;
          m_rdata = (m_cur.op == 2'd0) ? bus.core_rdata_i : '0;
          m_ph    = PH_RSP;
        end else if (m_wait + 1 == TO) begin
          m_rop = m_cur.op; m_rhit = 1'b0; m_rerr = 1'b1; m_rdata = '0;
          m_ph  = PH_RSP;
        end else begin
          m_wait++;
        end
      end
      default: begin
        if (bus.rsp_ready_i) begin
`ifdef CMD_QUEUE_STATS_EN
          if (m_cmds < 16'hFFFF) m_cmds++;
          if (m_rhit && m_hits < 16'hFFFF) m_hits++;
`endif
          m_ph = PH_FREE;
        end
      end
    endcase
    if (accepted) begin
      c.op  = bus.cmd_op_i;
      c.key = bus.cmd_key_i;
      c.val = bus.cmd_val_i;
      mq.push_back(c);
    end
    m_level = m_level + int'(accepted) - int'(taken);
  endtask

  task automatic check_outputs();
    chk("level", VW'(bus.level_o), VW'(m_level));
    chk("cmd_ready", VW'(bus.cmd_ready_o), VW'(m_level != DEPTH));
    chk("core_start", VW'(bus.core_start_o), VW'(m_ph == PH_START));
    if (m_ph == PH_START) begin
      chk("core_op", VW'(bus.core_op_o), VW'(m_cur.op));
      chk("core_key", VW'(bus.core_key_o), VW'(m_cur.key));
      chk("core_val", bus.core_val_o, m_cur.val);
    end
    chk("rsp_valid", VW'(bus.rsp_valid_o), VW'(m_ph == PH_RSP));
    if (m_ph == PH_RSP) begin
      chk("rsp_op", VW'(bus.rsp_op_o), VW'(m_rop));
      chk("rsp_hit", VW'(bus.rsp_hit_o), VW'(m_rhit));
      chk("rsp_err", VW'(bus.rsp_err_o), VW'(m_rerr));
      chk("rsp_data", bus.rsp_data_o, m_rdata);
    end
`ifdef CMD_QUEUE_STATS_EN
    chk("stat_cmds", VW'(stat_cmds), VW'(m_cmds));
    chk("stat_hits", VW'(stat_hits), VW'(m_hits));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_level", VW'(bus.level_o), '0);
    chk("rst_ready", VW'(bus.cmd_ready_o), 1);
    chk("rst_start", VW'(bus.core_start_o), '0);
    chk("rst_core_op", VW'(bus.core_op_o), '0);
    chk("rst_core_key", VW'(bus.core_key_o), '0);
    chk("rst_core_val", bus.core_val_o, '0);
    chk("rst_rsp_valid", VW'(bus.rsp_valid_o), '0);
    chk("rst_rsp_op", VW'(bus.rsp_op_o), '0);
    chk("rst_rsp_hit", VW'(bus.rsp_hit_o), '0);
    chk("rst_rsp_err", VW'(bus.rsp_err_o), '0);
    chk("rst_rsp_data", bus.rsp_data_o, '0);
    model_clear();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_key_i   = key;
    bus.cmd_val_i   = val;
    step();
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rst_n = 1'b1;
    #2;
    do_reset();

    // Single READ with a hit
    push_one(2'd0, 16'h0042, 64'h0);
    bus.core_done_i  = 1'b1;
    bus.core_hit_i   = 1'b1;
    bus.core_rdata_i = 64'hDEAD;
    repeat (6) step();

    // Fill the queue while the core is busy, then drain in order
    idle_inputs();
    bus.core_busy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = 2'(i % 3);
      bus.cmd_key_i   = KW'(16'h0100 + i);
      bus.cmd_val_i   = VW'(i);
      step();
    end
    chk("full_level", VW'(bus.level_o), VW'(DEPTH));
    chk("full_ready", VW'(bus.cmd_ready_o), '0);
    bus.cmd_valid_i  = 1'b0;
    bus.core_busy_i  = 1'b0;
    bus.core_done_i  = 1'b1;
    bus.core_hit_i   = 1'b0;
    bus.core_rdata_i = 64'h1234_5678_9ABC_DEF0;
    repeat (40) step();

    // Reserved op answered with an error, never issued
    idle_inputs();
    push_one(2'd3, 16'h0BAD, 64'h77);
    repeat (5) step();

    // Core never answers: timeout response
    idle_inputs();
    push_one(2'd0, 16'h0055, 64'h0);
    repeat (TO + 8) step();

    // Response back-pressure for several cycles
    idle_inputs();
    bus.rsp_ready_i  = 1'b0;
    bus.core_done_i  = 1'b1;
    bus.core_hit_i   = 1'b1;
    bus.core_rdata_i = 64'hCAFE;
    push_one(2'd0, 16'h0001, 64'h0);
    push_one(2'd1, 16'h0002, 64'h99);
    repeat (12) step();
    bus.rsp_ready_i = 1'b1;
    repeat (20) step();

    // Reset while waiting on the core with three commands queued
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = 2'd0;
      bus.cmd_key_i   = KW'(16'h0200 + i);
      bus.cmd_val_i   = '0;
      step();
    end
    bus.cmd_valid_i = 1'b0;
    chk("pre_rst_level", VW'(bus.level_o), 3);
    do_reset();
    repeat (10) step();

    // Randomized traffic under several load mixes
    for (int k = 0; k < 4; k++) begin
      int pv, pb, pd, pr;
      pv = (k == 0) ? 30 : (k == 1) ? 80 : (k == 2) ? 60 : 50;
      pb = (k == 0) ? 10 : (k == 1) ? 50 : (k == 2) ? 20 : 30;
      pd = (k == 0) ? 50 : (k == 1) ? 30 : (k == 2) ? 4  : 20;
      pr = (k == 0) ? 90 : (k == 1) ? 40 : (k == 2) ? 70 : 20;
      for (int n = 0; n < 600; n++) begin
        rand_inputs(pv, pb, pd, pr);
        step();
      end
      if (k == 1) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
